// File: rtl/uwu_uart_rx.sv
// uwu_uart_rx: 8N1 UART receiver with a two-flop synchronizer, mid-bit sampling,
// a small byte FIFO on a valid/ready output, and framing/overrun error pulses.
module uwu_uart_rx #(
    parameter int CLK_FREQ   = 6000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int CPB  = CLK_FREQ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB) > 0 ? $clog2(CPB) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;

    logic          s1_q, s2_q;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bitidx_q, bitidx_d;
    logic [7:0]    shift_q, shift_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW:0]   wptr_q, rptr_q;
    logic          full, pop, push, can_accept;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign full       = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign out_valid  = wptr_q != rptr_q;
    assign out_data   = mem_q[rptr_q[AW-1:0]];
    assign pop        = out_valid && out_ready;
    assign can_accept = !full || pop;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = state_q != IDLE;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bitidx_d    = bitidx_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        case (state_q)
            IDLE: if (!s2_q) begin
                state_d = START;
                cnt_d   = '0;
            end
            START: if (cnt_q == CW'(HALF - 1)) begin
                state_d  = s2_q ? IDLE : DATA;
                cnt_d    = '0;
                bitidx_d = '0;
            end else cnt_d = cnt_q + CW'(1);
            DATA: if (cnt_q == CW'(CPB - 1)) begin
                shift_d  = {s2_q, shift_q[7:1]};
                cnt_d    = '0;
                bitidx_d = bitidx_q + 3'd1;
                state_d  = bitidx_q == 3'd7 ? STOP : DATA;
            end else cnt_d = cnt_q + CW'(1);
            STOP: if (cnt_q == CW'(CPB - 1)) begin
                cnt_d       = '0;
                push        = s2_q && can_accept;
                overrun_d   = s2_q && !can_accept;
                frame_err_d = !s2_q;
                state_d     = s2_q ? IDLE : WAIT_HIGH;
            end else cnt_d = cnt_q + CW'(1);
            WAIT_HIGH: state_d = s2_q ? IDLE : WAIT_HIGH;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= 1'b1;
            s2_q        <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bitidx_q    <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            s1_q        <= rx;
            s2_q        <= s1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bitidx_q    <= bitidx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            if (push) begin
                mem_q[wptr_q[AW-1:0]] <= shift_d;
                wptr_q                <= wptr_q + (AW + 1)'(1);
            end
            if (pop) rptr_q <= rptr_q + (AW + 1)'(1);
        end
    end
endmodule

// File: tb/tb_uwu_uart_rx.sv
// tb_uwu_uart_rx: directed frames for uwu_uart_rx; expected bytes and error
// events are queued by the stimulus and consumed by an independent monitor.
module tb_uwu_uart_rx;
    localparam int CPB  = 52;
    localparam int PUSH = 496;

    logic       clk = 0;
    logic       rst = 1;
    logic       rx = 1;
    logic       out_ready = 0;
    logic [7:0] out_data;
    logic       out_valid, frame_err, overrun, busy;

    int         total = 0;
    int         bad = 0;
    int         n_pop = 0;
    logic [7:0] exp_q[$];
    int         exp_ev[$];

    uwu_uart_rx dut (
        .clk(clk), .rst(rst), .rx(rx),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends the first nbits bit-times of {stop, data, start}; the line is left as driven.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int nbits);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rx = f[i];
            tick(CPB);
        end
        if (nbits == 10) rx = 1'b1;
    endtask

    task automatic wait_bytes();
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) tick(1);
        check("expected bytes delivered", exp_q.size(), 0);
    endtask

    task automatic drain();
        out_ready = 1;
        for (int i = 0; i < 20 && out_valid; i++) tick(1);
        out_ready = 0;
        check("fifo empty after drain", out_valid, 0);
    endtask

    // Monitor: handshakes and error pulses are checked against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected byte: got %0h want none", out_data);
                end else check("byte", out_data, exp_q.pop_front());
            end
            if (frame_err || overrun) begin
                if (exp_ev.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected pulse: got frame_err=%0b overrun=%0b want none", frame_err, overrun);
                end else check("error pulse kind", {30'd0, overrun, frame_err}, exp_ev.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n0;
        tick(4);
        rst = 0;
        tick(2);
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset busy", busy, 0);
        check("reset frame_err", frame_err, 0);
        check("reset overrun", overrun, 0);

        // Single byte, latency and hold
        exp_q.push_back(8'h55);
        fork
            send_frame(8'h55, 1'b1, 10);
            begin
                tick(PUSH);
                check("valid low before push edge", out_valid, 0);
                tick(1);
                check("valid after push edge", out_valid, 1);
                check("data after push edge", out_data, 8'h55);
            end
        join
        ok = 1;
        for (int i = 0; i < 100; i++) begin
            if (!out_valid || out_data != 8'h55) ok = 0;
            tick(1);
        end
        check("data held while not ready", ok, 1);
        out_ready = 1;
        tick(1);
        out_ready = 0;
        check("valid drops after pop", out_valid, 0);

        // Sequence with overrun on the fifth byte
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        exp_ev.push_back(2);
        send_frame(8'h00, 1'b1, 10);
        send_frame(8'hFF, 1'b1, 10);
        send_frame(8'hA5, 1'b1, 10);
        send_frame(8'h3C, 1'b1, 10);
        send_frame(8'h7E, 1'b1, 10);
        check("overrun pulse seen", exp_ev.size(), 0);
        drain();
        check("sequence drained", exp_q.size(), 0);

        // Framing error followed by a break, then a good byte
        exp_ev.push_back(1);
        send_frame(8'h41, 1'b0, 10 - 1);
        rx = 0;
        tick(4 * CPB);
        rx = 1;
        check("frame_err pulse seen", exp_ev.size(), 0);
        check("no push on framing error", out_valid, 0);
        tick(2 * CPB);
        exp_q.push_back(8'h42);
        out_ready = 1;
        send_frame(8'h42, 1'b1, 10);
        wait_bytes();
        out_ready = 0;

        // Glitch rejection
        rx = 0;
        tick(4);
        check("busy during glitch", busy, 1);
        tick(6);
        rx = 1;
        tick(40);
        check("idle after glitch", busy, 0);
        check("no byte from glitch", out_valid, 0);

        // Full FIFO with a pop on the push edge of a fifth byte
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h99);
        send_frame(8'h11, 1'b1, 10);
        send_frame(8'h22, 1'b1, 10);
        send_frame(8'h33, 1'b1, 10);
        send_frame(8'h44, 1'b1, 10);
        fork
            send_frame(8'h99, 1'b1, 10);
            begin
                tick(PUSH);
                out_ready = 1;
                tick(1);
                out_ready = 0;
            end
        join
        n0 = n_pop;
        drain();
        check("entries after simultaneous push/pop", n_pop - n0, 4);
        check("full-case bytes consumed", exp_q.size(), 0);

        // Reset in the middle of data bit 3
        send_frame(8'h6B, 1'b1, 4);
        rx = 1;
        tick(CPB / 2);
        check("busy before mid-frame reset", busy, 1);
        rst = 1;
        tick(1);
        rst = 0;
        check("mid reset out_valid", out_valid, 0);
        check("mid reset busy", busy, 0);
        check("mid reset out_data", out_data, 0);
        check("mid reset pulses", {frame_err, overrun}, 0);
        tick(12 * CPB);
        check("no byte after mid reset", out_valid, 0);
        exp_q.push_back(8'h6B);
        out_ready = 1;
        send_frame(8'h6B, 1'b1, 10);
        wait_bytes();
        out_ready = 0;

        tick(10);
        check("leftover events", exp_ev.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
